scr1_tcm_port_arb: RTL and testbench

- Shares one single-port TCM SRAM macro between the core instruction and data memory interfaces.
- Accepts SCR1 native req/ack requests from both ports and grants at most one per cycle. Data port has fixed priority, with optional starvation protection for the instruction port.
- Generates SRAM strobes and byte enables, and returns rdata/resp one cycle after grant.
- Sits inside the TCM wrapper, between the core top and the SRAM.

---
 rtl/scr1_tcm_port_arb.sv | 175 +++++++++++++++++
 tb/tb_scr1_tcm_port_arb.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scr1_tcm_port_arb.sv
// scr1_tcm_port_arb
//   Shares one single-port TCM SRAM between the core instruction (imem) and
//   data (dmem) SCR1 native req/ack interfaces. At most one SRAM access is
//   granted per cycle. dmem has fixed priority. Read data and responses come
//   back one cycle after the grant.
//
// Optional feature (macro SCR1_TCM_ARB_STARVE_EN):
//   When the macro is defined, a saturating counter tracks consecutive cycles
//   in which imem requested but was denied. Once it reaches STARVE_LIMIT, imem
//   wins over a legal dmem request. When the macro is undefined, dmem has
//   strict priority and imem may starve.
//
// Ports:
//   clk, rst_n                        core clock, async active-low reset
//   imem_req/addr                     instruction fetch request
//   imem_req_ack                      fetch accepted this cycle
//   imem_rdata/resp                   fetch data / response (IDLE, RDY, ER)
//   dmem_req/cmd/width/addr/wdata     data request
//   dmem_req_ack                      data request accepted this cycle
//   dmem_rdata/resp                   raw SRAM word / response
//   sram_ce/we/addr/be/wdata          SRAM strobe, write enable, word address,
//                                     byte enables, lane-replicated write data
//   sram_rdata                        SRAM read data, one cycle after strobe
`timescale 1ns/1ps

module scr1_tcm_port_arb #(
    parameter int TCM_ADDR_W   = 14,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  imem_req,
    input  logic [31:0]           imem_addr,
    output logic                  imem_req_ack,
    output logic [31:0]           imem_rdata,
    output logic [1:0]            imem_resp,
    input  logic                  dmem_req,
    input  logic                  dmem_cmd,
    input  logic [1:0]            dmem_width,
    input  logic [31:0]           dmem_addr,
    input  logic [31:0]           dmem_wdata,
    output logic                  dmem_req_ack,
    output logic [31:0]           dmem_rdata,
    output logic [1:0]            dmem_resp,
    output logic                  sram_ce,
    output logic                  sram_we,
    output logic [TCM_ADDR_W-1:0] sram_addr,
    output logic [3:0]            sram_be,
    output logic [31:0]           sram_wdata,
    input  logic [31:0]           sram_rdata
);

    localparam logic [1:0] RESP_IDLE = 2'd0;
    localparam logic [1:0] RESP_RDY  = 2'd1;
    localparam logic [1:0] RESP_ER   = 2'd2;

    logic dmem_illegal;
    logic force_imem;
    logic dmem_gnt;
    logic dmem_err;
    logic imem_gnt;

    logic        imem_pend;
    logic        dmem_rd_pend;
    logic        dmem_wr_pend;
    logic        dmem_er_pend;
    logic [31:0] imem_rdata_q;
    logic [31:0] dmem_rdata_q;

    // Address bits above the TCM window alias; imem low bits are don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{imem_addr[31:TCM_ADDR_W+2], imem_addr[1:0],
                                dmem_addr[31:TCM_ADDR_W+2]};

    always_comb begin
        case (dmem_width)
            2'd0:    dmem_illegal = 1'b0;
            2'd1:    dmem_illegal = dmem_addr[0];
            2'd2:    dmem_illegal = |dmem_addr[1:0];
            default: dmem_illegal = 1'b1;
        endcase
    end

`ifdef SCR1_TCM_ARB_STARVE_EN
    logic [3:0] starve_cnt;

    // Gated by imem_req so a stale count never blocks dmem once imem backs off.
    assign force_imem = imem_req && (starve_cnt >= 4'(STARVE_LIMIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 4'd0;
        end else if (imem_req && !imem_gnt) begin
            if (starve_cnt != 4'hF) starve_cnt <= starve_cnt + 4'd1;
        end else begin
            starve_cnt <= 4'd0;
        end
    end
`else
    localparam int UNUSED_STARVE_LIMIT = STARVE_LIMIT;
    assign force_imem = 1'b0;
`endif

    // Illegal dmem requests are acked without touching the SRAM, so imem can
    // use the slot in the same cycle. Reset masks every grant.
    assign dmem_gnt = rst_n && dmem_req && !dmem_illegal && !force_imem;
    assign dmem_err = rst_n && dmem_req && dmem_illegal;
    assign imem_gnt = rst_n && imem_req && !dmem_gnt;

    assign dmem_req_ack = dmem_gnt || dmem_err;
    assign imem_req_ack = imem_gnt;

    always_comb begin
        sram_ce    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_be    = 4'h0;
        sram_wdata = 32'h0;
        if (dmem_gnt) begin
            sram_ce   = 1'b1;
            sram_addr = dmem_addr[TCM_ADDR_W+1:2];
            if (dmem_cmd) begin
                sram_we = 1'b1;
                case (dmem_width)
                    2'd0: begin
                        sram_be    = 4'b0001 << dmem_addr[1:0];
                        sram_wdata = {4{dmem_wdata[7:0]}};
                    end
                    2'd1: begin
                        sram_be    = 4'b0011 << dmem_addr[1:0];
                        sram_wdata = {2{dmem_wdata[15:0]}};
                    end
                    default: begin
                        sram_be    = 4'hF;
                        sram_wdata = dmem_wdata;
                    end
                endcase
            end else begin
                sram_be = 4'hF;
            end
        end else if (imem_gnt) begin
            sram_ce   = 1'b1;
            sram_addr = imem_addr[TCM_ADDR_W+1:2];
            sram_be   = 4'hF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_pend    <= 1'b0;
            dmem_rd_pend <= 1'b0;
            dmem_wr_pend <= 1'b0;
            dmem_er_pend <= 1'b0;
            imem_rdata_q <= 32'h0;
            dmem_rdata_q <= 32'h0;
        end else begin
            imem_pend    <= imem_gnt;
            dmem_rd_pend <= dmem_gnt && !dmem_cmd;
            dmem_wr_pend <= dmem_gnt && dmem_cmd;
            dmem_er_pend <= dmem_err;
            if (imem_pend)    imem_rdata_q <= sram_rdata;
            if (dmem_rd_pend) dmem_rdata_q <= sram_rdata;
        end
    end

    // SRAM data is only valid in the response cycle; hold it afterwards so
    // rdata stays put through writes and idle cycles.
    assign imem_rdata = imem_pend    ? sram_rdata : imem_rdata_q;
    assign dmem_rdata = dmem_rd_pend ? sram_rdata : dmem_rdata_q;

    assign imem_resp = imem_pend ? RESP_RDY : RESP_IDLE;
    assign dmem_resp = (dmem_rd_pend || dmem_wr_pend) ? RESP_RDY :
                       dmem_er_pend ? RESP_ER : RESP_IDLE;

endmodule

// File: tb/tb_scr1_tcm_port_arb.sv
// Testbench for scr1_tcm_port_arb: directed cases plus randomized traffic,
// checked against a byte-level memory model and a response scoreboard.
`timescale 1ns/1ps

module tb_scr1_tcm_port_arb;
    localparam int AW    = 14;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          imem_req = 1'b0;
    logic [31:0]   imem_addr = '0;
    logic          imem_req_ack;
    logic [31:0]   imem_rdata;
    logic [1:0]    imem_resp;
    logic          dmem_req = 1'b0;
    logic          dmem_cmd = 1'b0;
    logic [1:0]    dmem_width = '0;
    logic [31:0]   dmem_addr = '0;
    logic [31:0]   dmem_wdata = '0;
    logic          dmem_req_ack;
    logic [31:0]   dmem_rdata;
    logic [1:0]    dmem_resp;
    logic          sram_ce;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [3:0]    sram_be;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata;

    always #5 clk = ~clk;

    scr1_tcm_port_arb #(.TCM_ADDR_W(AW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_req_ack(imem_req_ack),
        .imem_rdata(imem_rdata), .imem_resp(imem_resp),
        .dmem_req(dmem_req), .dmem_cmd(dmem_cmd), .dmem_width(dmem_width),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_req_ack(dmem_req_ack),
        .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_be(sram_be), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    // SRAM macro model: registered read, byte-enabled write.
    logic [31:0] sram_mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_we) begin
                for (int b = 0; b < 4; b++)
                    if (sram_be[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end else begin
                sram_rdata <= sram_mem[sram_addr];
            end
        end
    end

    // Reference model: TCM as a flat byte array indexed modulo its size.
    logic [7:0] ref_mem [int];
    typedef struct { int due; logic [1:0] resp; logic [31:0] data; bit chk_data; } exp_t;
    exp_t iq[$];
    exp_t dq[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int starve = 0;
    logic [31:0] last_i = '0;
    logic [31:0] last_d = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int byte_idx(input logic [31:0] a);
        return int'(a % (32'd4 << AW));
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0] w;
        int base;
        base = byte_idx(a) & ~3;
        w = '0;
        for (int b = 0; b < 4; b++)
            if (ref_mem.exists(base + b)) w[8*b +: 8] = ref_mem[base + b];
        return w;
    endfunction

    function automatic bit is_illegal(input logic [1:0] w, input logic [31:0] a);
        return (w == 2'd3) || (w == 2'd1 && a % 2 != 0) || (w == 2'd2 && a % 4 != 0);
    endfunction

    task automatic drive(input bit ir, input logic [31:0] ia,
                         input bit dr, input bit dc, input logic [1:0] dw,
                         input logic [31:0] da, input logic [31:0] dwd,
                         output bit e_iack, output bit e_dack);
        bit ill, force_i, e_dgnt, e_ce;
        int off, nb;
        logic [3:0]  e_be;
        logic [31:0] e_wd, e_addr;
        exp_t e;
        @(negedge clk);
        imem_req = ir; imem_addr = ia;
        dmem_req = dr; dmem_cmd = dc; dmem_width = dw; dmem_addr = da; dmem_wdata = dwd;
        #1;
        ill = is_illegal(dw, da);
`ifdef SCR1_TCM_ARB_STARVE_EN
        force_i = ir && (starve >= LIMIT);
`else
        force_i = 1'b0;
`endif
        e_dgnt = dr && !ill && !force_i;
        e_iack = ir && !e_dgnt;
        e_dack = e_dgnt || (dr && ill);
        starve = (ir && !e_iack) ? ((starve < 15) ? starve + 1 : 15) : 0;
        chk("imem_req_ack", {31'b0, imem_req_ack}, {31'b0, e_iack});
        chk("dmem_req_ack", {31'b0, dmem_req_ack}, {31'b0, e_dack});

        e_ce = e_dgnt || e_iack;
        chk("sram_ce", {31'b0, sram_ce}, {31'b0, e_ce});
        if (e_ce) begin
            e_addr = (e_dgnt ? da : ia) / 4 % (32'd1 << AW);
            chk("sram_addr", {{(32-AW){1'b0}}, sram_addr}, e_addr);
            chk("sram_we", {31'b0, sram_we}, {31'b0, e_dgnt && dc});
        end
        if (e_dgnt && dc) begin
            off = int'(da % 4);
            nb = (dw == 2'd0) ? 1 : (dw == 2'd1) ? 2 : 4;
            e_be = 4'((nb == 1) ? (1 << off) : (nb == 2) ? (3 << off) : 15);
            e_wd = (nb == 1) ? dwd[7:0] * 32'h0101_0101 :
                   (nb == 2) ? dwd[15:0] * 32'h0001_0001 : dwd;
            chk("sram_be", {28'b0, sram_be}, {28'b0, e_be});
            chk("sram_wdata", sram_wdata, e_wd);
            for (int b = 0; b < nb; b++)
                ref_mem[(byte_idx(da) & ~3) + off + b] = dwd[8*b +: 8];
        end else if (e_ce) begin
            chk("sram_be_rd", {28'b0, sram_be}, 32'hF);
        end

        if (e_iack) begin
            last_i = ref_word(ia);
            e = '{due: cyc + 1, resp: 2'd1, data: last_i, chk_data: 1'b1};
            iq.push_back(e);
        end
        if (e_dgnt) begin
            if (!dc) last_d = ref_word(da);
            e = '{due: cyc + 1, resp: 2'd1, data: last_d, chk_data: 1'b1};
            dq.push_back(e);
        end else if (e_dack) begin
            e = '{due: cyc + 1, resp: 2'd2, data: last_d, chk_data: 1'b0};
            dq.push_back(e);
        end
    endtask

    // Response monitor, decoupled from stimulus.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (iq.size() > 0 && iq[0].due == cyc) begin
            e = iq.pop_front();
            chk("imem_resp", {30'b0, imem_resp}, {30'b0, e.resp});
            chk("imem_rdata", imem_rdata, e.data);
        end else begin
            chk("imem_resp_idle", {30'b0, imem_resp}, 32'd0);
        end
        if (dq.size() > 0 && dq[0].due == cyc) begin
            e = dq.pop_front();
            chk("dmem_resp", {30'b0, dmem_resp}, {30'b0, e.resp});
            if (e.chk_data) chk("dmem_rdata", dmem_rdata, e.data);
        end else begin
            chk("dmem_resp_idle", {30'b0, dmem_resp}, 32'd0);
        end
    end

    task automatic idle(input int n);
        bit a, b;
        for (int k = 0; k < n; k++) drive(0, '0, 0, 0, 2'd0, '0, '0, a, b);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_iack"}, {31'b0, imem_req_ack}, 32'd0);
        chk({tag, "_dack"}, {31'b0, dmem_req_ack}, 32'd0);
        chk({tag, "_ce"}, {31'b0, sram_ce}, 32'd0);
        chk({tag, "_we_be"}, {27'b0, sram_we, sram_be}, 32'd0);
        chk({tag, "_addr"}, {{(32-AW){1'b0}}, sram_addr}, 32'd0);
        chk({tag, "_wdata"}, sram_wdata, 32'd0);
        chk({tag, "_resp"}, {28'b0, imem_resp, dmem_resp}, 32'd0);
        chk({tag, "_irdata"}, imem_rdata, 32'd0);
        chk({tag, "_drdata"}, dmem_rdata, 32'd0);
    endtask

    initial begin
        bit ia_ack, da_ack, pi, pd, dc;
        logic [1:0]  dw;
        logic [31:0] ia, da, dwd;
        int first_i, n_i;

        for (int k = 0; k < (1 << AW); k++) sram_mem[k] = '0;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk) rst_n = 1'b1;

        // Word write then imem fetch of 0x100.
        drive(0, '0, 1, 1, 2'd2, 32'h100, 32'hDEAD_BEEF, ia_ack, da_ack);
        drive(1, 32'h100, 0, 0, 2'd0, '0, '0, ia_ack, da_ack);
        chk("plan_imem_addr", {{(32-AW){1'b0}}, sram_addr}, 32'h40);
        idle(1);

        // Byte write 0xA5 to 0x203, then word read of 0x200.
        drive(0, '0, 1, 1, 2'd0, 32'h203, 32'h0000_00A5, ia_ack, da_ack);
        chk("plan_byte_be", {28'b0, sram_be}, 32'h8);
        chk("plan_byte_wdata", sram_wdata, 32'hA5A5_A5A5);
        drive(0, '0, 1, 0, 2'd2, 32'h200, '0, ia_ack, da_ack);
        idle(1);

        // Both ports requesting every cycle for 20 cycles.
        first_i = -1; n_i = 0;
        for (int k = 0; k < 20; k++) begin
            drive(1, 32'h100, 1, 0, 2'd2, 32'h200, '0, ia_ack, da_ack);
            if (imem_req_ack) begin
                n_i++;
                if (first_i < 0) first_i = k;
            end
        end
`ifdef SCR1_TCM_ARB_STARVE_EN
        chk("starve_first_imem", first_i, LIMIT);
`else
        chk("starve_imem_count", n_i, 0);
`endif
        idle(1);

        // Illegal half read at 0x301 alongside an imem fetch.
        drive(1, 32'h100, 1, 0, 2'd1, 32'h301, '0, ia_ack, da_ack);
        chk("plan_ill_imem_gets_sram", {{(32-AW){1'b0}}, sram_addr}, 32'h40);
        drive(0, '0, 1, 0, 2'd1, 32'h301, '0, ia_ack, da_ack);
        chk("plan_ill_no_ce", {31'b0, sram_ce}, 32'd0);
        idle(1);

        // Alias: write at 0x4, read at 0x0001_0004.
        drive(0, '0, 1, 1, 2'd2, 32'h4, 32'h1234_5678, ia_ack, da_ack);
        drive(0, '0, 1, 0, 2'd2, 32'h0001_0004, '0, ia_ack, da_ack);
        chk("plan_alias_addr", {{(32-AW){1'b0}}, sram_addr}, 32'h1);
        idle(1);

        // Reset in the response cycle of a grant drops the response.
        drive(1, 32'h4, 1, 0, 2'd2, 32'h200, '0, ia_ack, da_ack);
        @(posedge clk);
        #1 rst_n = 1'b0;
        iq.delete(); dq.delete();
        starve = 0; last_i = '0; last_d = '0;
        #0.5 check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        imem_req = 0; dmem_req = 0;
        imem_addr = '0; dmem_addr = '0; dmem_wdata = '0; dmem_cmd = 0; dmem_width = '0;
        rst_n = 1'b1;
        #1 check_reset_outputs("postrst");
        idle(3);

        // Randomized traffic; requests are held until acked.
        pi = 0; pd = 0; dc = 0; dw = '0; ia = '0; da = '0; dwd = '0;
        for (int n = 0; n < 3000; n++) begin
            if (!pi) begin
                pi = ($urandom % 3) != 0;
                ia = ($urandom & 32'hFFFF_0000) | $urandom_range(0, 63);
            end
            if (!pd) begin
                pd = $urandom % 2;
                dc = $urandom % 2;
                dw = 2'($urandom % 4);
                dwd = $urandom;
                da = ($urandom & 32'hFFFF_0000) | $urandom_range(0, 63);
                if ($urandom % 4 != 0) begin
                    if (dw == 2'd1) da[0] = 1'b0;
                    if (dw == 2'd2) da[1:0] = 2'b00;
                end
            end
            drive(pi, ia, pd, dc, dw, da, dwd, ia_ack, da_ack);
            if (ia_ack) pi = 0;
            if (da_ack) pd = 0;
        end
        idle(3);
        @(posedge clk);
        #3 chk("scoreboard_drained", iq.size() + dq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
